nibble_byte_assembler: RTL and testbench

- Receive side of the nibble-swapped byte link: accepts a 4-bit nibble stream from the swapping transmitter and rebuilds the original bytes.
- Undoes the swap, buffers the rebuilt bytes in a small FIFO and presents them on a valid/ready port.
- Instantiated inside a TinyTapeout top.
- Nibble inputs come from ui_in/uio_in; bytes drain to uo_out-side logic.

---
 rtl/nibble_byte_assembler.sv | 127 ++++++++++++
 tb/tb_nibble_byte_assembler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_byte_assembler.sv
// Receive side of the nibble-swapped byte link: pairs incoming nibbles back into
// bytes, buffers them in a show-ahead FIFO and drains them over valid/ready.
module nibble_byte_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter bit LO_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          nib_valid,
  input  logic                          nib_first,
  input  logic [3:0]                    nib_data,
  output logic                          byte_valid,
  output logic [7:0]                    byte_data,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          sync_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      held_q, held_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            sync_err_q, sync_err_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            ovf_evt;
  logic            sync_evt;
  logic [7:0]      assembled;

  assign accept    = ena & nib_valid;
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign pop       = byte_valid & byte_ready;
  assign assembled = LO_FIRST ? {nib_data, held_q} : {held_q, nib_data};

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    push     = 1'b0;
    sync_evt = 1'b0;
    if (accept) begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (nib_first) begin
            held_d  = nib_data;
            state_d = WAIT_SECOND;
          end else begin
            sync_evt = 1'b1;
          end
        end
        WAIT_SECOND: begin
          if (nib_first) begin
            // Resync: the new first nibble replaces the orphaned one.
            held_d   = nib_data;
            sync_evt = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = WAIT_FIRST;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AW'(push_ok);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    overflow_d = (overflow_q & ~clr_err) | ovf_evt;
    sync_err_d = (sync_err_q & ~clr_err) | sync_evt;
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WAIT_FIRST;
      held_q     <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
    end
  end

  // NOTE: storage has no reset; empty pointers plus the output gate hide stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= assembled;
  end

  assign byte_valid = (level_q != '0);
  assign byte_data  = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_nibble_byte_assembler.sv
// Randomized and directed bench for nibble_byte_assembler; a queue-based model
// of both nibble orderings is checked against two DUT builds every cycle.
module tb_nibble_byte_assembler;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, nib_valid, nib_first, byte_ready, clr_err;
  logic [3:0] nib_data;

  logic       bv0, bv1, ov0, ov1, se0, se1;
  logic [7:0] bd0, bd1;
  logic [2:0] lv0, lv1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: expecting a second nibble?, held nibble, byte queues per ordering.
  bit         m_second;
  logic [3:0] m_held;
  logic [7:0] q_lo[$];
  logic [7:0] q_hi[$];
  bit         m_ovf, m_serr;

  always #5 clk = ~clk;

  nibble_byte_assembler #(.FIFO_DEPTH(DEPTH), .LO_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .ena(ena), .nib_valid(nib_valid), .nib_first(nib_first),
    .nib_data(nib_data), .byte_valid(bv0), .byte_data(bd0), .byte_ready(byte_ready),
    .level(lv0), .overflow(ov0), .sync_err(se0), .clr_err(clr_err)
  );

  nibble_byte_assembler #(.FIFO_DEPTH(DEPTH), .LO_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .ena(ena), .nib_valid(nib_valid), .nib_first(nib_first),
    .nib_data(nib_data), .byte_valid(bv1), .byte_data(bd1), .byte_ready(byte_ready),
    .level(lv1), .overflow(ov1), .sync_err(se1), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules of one clock edge to the model, using the inputs of that cycle.
  task automatic model_edge();
    bit         pop;
    bit         new_byte;
    logic [7:0] b_lo, b_hi;
    if (!rst_n) begin
      m_second = 0; m_held = 4'h0; m_ovf = 0; m_serr = 0;
      q_lo.delete(); q_hi.delete();
      return;
    end
    pop      = (q_lo.size() > 0) && byte_ready;
    new_byte = 0;
    if (clr_err) begin m_ovf = 0; m_serr = 0; end
    if (ena && nib_valid) begin
      if (!m_second) begin
        if (nib_first) begin m_held = nib_data; m_second = 1; end
        else m_serr = 1;
      end else if (nib_first) begin
        m_held = nib_data; m_serr = 1;
      end else begin
        b_lo = {nib_data, m_held};
        b_hi = {m_held, nib_data};
        new_byte = 1; m_second = 0;
      end
    end
    if (pop) begin void'(q_lo.pop_front()); void'(q_hi.pop_front()); end
    if (new_byte) begin
      if (q_lo.size() < DEPTH) begin q_lo.push_back(b_lo); q_hi.push_back(b_hi); end
      else m_ovf = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_lo", bv0, q_lo.size() > 0);
      check("data_lo", bd0, q_lo.size() > 0 ? q_lo[0] : 8'h00);
      check("level_lo", lv0, q_lo.size());
      check("ovf_lo", ov0, m_ovf);
      check("serr_lo", se0, m_serr);
      check("valid_hi", bv1, q_hi.size() > 0);
      check("data_hi", bd1, q_hi.size() > 0 ? q_hi[0] : 8'h00);
      check("level_hi", lv1, q_hi.size());
      check("ovf_hi", ov1, m_ovf);
      check("serr_hi", se1, m_serr);
    end
  end

  task automatic step(input bit rst, input bit en, input bit v, input bit f,
                      input logic [3:0] d, input bit rdy, input bit clr);
    rst_n = rst; ena = en; nib_valid = v; nib_first = f;
    nib_data = d; byte_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1, 1, 0, 0, 4'h0, rdy, 0);
  endtask

  // Sends a byte low nibble first, so dut_lo rebuilds it unchanged.
  task automatic send_byte(input logic [7:0] b, input bit rdy_last);
    step(1, 1, 1, 1, b[3:0], 0, 0);
    step(1, 1, 1, 0, b[7:4], rdy_last, 0);
  endtask

  task automatic clear_flags();
    step(1, 1, 0, 0, 4'h0, 0, 1);
  endtask

  initial begin
    logic [7:0] seq [5];
    logic [7:0] last;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44; seq[4] = 8'h55;

    rst_n = 0; ena = 0; nib_valid = 0; nib_first = 0; nib_data = 0; byte_ready = 0; clr_err = 0;
    @(negedge clk); #1;
    step(0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 0);
    chk_en = 1'b1;
    check("rst_level", lv0, 0);
    check("rst_data", bd0, 8'h00);
    check("rst_flags", {ov0, se0, bv0}, 3'b000);

    // Basic assembly and one-cycle latency.
    step(1, 1, 1, 1, 4'h3, 0, 0);
    check("no_partial", bv0, 0);
    step(1, 1, 1, 0, 4'hA, 0, 0);
    check("first_byte_lo", bd0, 8'hA3);
    check("first_byte_hi", bd1, 8'h3A);
    check("first_level", lv0, 1);
    idle(1);
    check("drained_valid", bv0, 0);
    check("drained_data", bd0, 8'h00);

    // Overflow: five bytes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) send_byte(seq[i], 0);
    check("ovf_level", lv0, 4);
    check("ovf_flag", ov0, 1);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", bd0, seq[i]);
      idle(1);
    end
    check("drain_empty", bv0, 0);
    clear_flags();
    check("ovf_cleared", ov0, 0);

    // Full FIFO with a simultaneous pop takes the fifth byte.
    for (int i = 0; i < 4; i++) send_byte(seq[i], 0);
    send_byte(seq[4], 1);
    check("full_pushpop_level", lv0, 4);
    check("full_pushpop_ovf", ov0, 0);
    last = 8'h00;
    for (int i = 0; i < 4; i++) begin last = bd0; idle(1); end
    check("last_out", last, 8'h55);

    // Framing errors.
    step(1, 1, 1, 0, 4'h6, 0, 0);
    check("stray_serr", se0, 1);
    check("stray_nobyte", lv0, 0);
    clear_flags();
    step(1, 1, 1, 1, 4'h7, 0, 0);
    step(1, 1, 1, 1, 4'hC, 0, 0);
    step(1, 1, 1, 0, 4'h2, 0, 0);
    check("resync_serr", se0, 1);
    check("resync_byte", bd0, 8'h2C);
    check("resync_level", lv0, 1);
    idle(1);
    clear_flags();
    check("serr_cleared", se0, 0);
    step(1, 1, 1, 0, 4'h1, 0, 1);
    check("set_wins", se0, 1);
    clear_flags();

    // Reset in the middle of a byte.
    step(1, 1, 1, 1, 4'h9, 0, 0);
    step(0, 1, 0, 0, 4'h0, 0, 0);
    step(1, 1, 1, 0, 4'h1, 0, 0);
    check("rst_mid_serr", se0, 1);
    check("rst_mid_nobyte", lv0, 0);
    clear_flags();

    // ena=0 freezes the assembler but not the drain.
    send_byte(8'hB7, 0);
    step(1, 1, 1, 1, 4'h4, 0, 0);
    step(1, 0, 1, 1, 4'hF, 0, 0);
    step(1, 0, 1, 0, 4'hE, 1, 0);
    check("ena_pop", lv0, 0);
    check("ena_no_serr", se0, 0);
    step(1, 1, 1, 0, 4'h6, 0, 0);
    check("ena_resume", bd0, 8'h64);
    idle(1);

    // Hi-first ordering.
    step(1, 1, 1, 1, 4'hA, 0, 0);
    step(1, 1, 1, 0, 4'h3, 0, 0);
    check("hi_first_byte", bd1, 8'hA3);
    idle(1);

    // Randomized traffic, mostly well-framed.
    for (int i = 0; i < 3000; i++) begin
      bit f;
      f = m_second ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           f, 4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
